// File: rtl/pulse_sched.sv
// -----------------------------------------------------------------------------
// pulse_sched
//
// Round-robin scheduler that time-shares one PulseSign pulse generator among
// six motor requesters. A requester raises Req[i] with its pulse count on
// ReqNum[10i+9:10i]. The scheduler grants one requester at a time. It drives
// Motor / PulseNum / Enable to the generator, follows the generator's Busy
// through the move, and reports completion with a Done pulse. Between moves
// it holds Enable low for GAP_CYCLES cycles so the generator clears itself.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   When defined, a 20-bit watchdog aborts a move that has not completed
//   TIMEOUT cycles after its grant. The abort pulses Err[Motor] and produces
//   no Done. When undefined, Err is tied to zero and LOAD/RUN wait forever.
//
// Parameters:
//   GAP_CYCLES  idle cycles with Enable=0 between moves (>= 1)
//   TIMEOUT     watchdog limit in cycles (used only with SCHED_TIMEOUT_EN)
//
// Ports:
//   clk        in   1   system clock, shared with PulseSign
//   rst        in   1   asynchronous active-low reset
//   Req        in   6   per-motor move request (level)
//   ReqNum     in  60   per-motor pulse counts, motor i at [10i+9:10i]
//   Ack        out  6   one-cycle grant pulse
//   Done       out  6   one-cycle move-complete pulse
//   Err        out  6   one-cycle watchdog-abort pulse
//   Motor      out  3   motor select to PulseSign
//   PulseNum   out 10   latched pulse count to PulseSign
//   Enable     out  1   enable to PulseSign
//   Busy       in   1   busy flag from PulseSign
//   SchedBusy  out  1   high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module pulse_sched #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Req,
    input  logic [59:0] ReqNum,
    output logic [5:0]  Ack,
    output logic [5:0]  Done,
    output logic [5:0]  Err,
    output logic [2:0]  Motor,
    output logic [9:0]  PulseNum,
    output logic        Enable,
    input  logic        Busy,
    output logic        SchedBusy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Registered state and outputs
    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [5:0]       r_ack;
    logic [5:0]       r_done;
    logic [2:0]       r_motor;
    logic [9:0]       r_pnum;
    logic             r_enable;
    logic             r_sched_busy;

    // Next-state values
    state_t           w_state_next;
    logic [2:0]       w_ptr_next;
    logic [GAP_W-1:0] w_gap_next;
    logic [5:0]       w_ack_next;
    logic [5:0]       w_done_next;
    logic [2:0]       w_motor_next;
    logic [9:0]       w_pnum_next;
    logic             w_enable_next;
    logic             w_sched_busy_next;

    // Round-robin search: candidate gi is the motor gi positions after ptr
    logic [3:0] w_cand_sum [6];
    logic [2:0] w_cand_idx [6];
    logic [5:0] w_cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_cand
            assign w_cand_sum[gi] = {1'b0, r_ptr} + 4'(gi);
            assign w_cand_idx[gi] = (w_cand_sum[gi] >= 4'd6) ? 3'(w_cand_sum[gi] - 4'd6)
                                                              : w_cand_sum[gi][2:0];
            assign w_cand_req[gi] = Req[w_cand_idx[gi]];
        end
    endgenerate

    logic       w_grant_valid;
    logic [2:0] w_grant_idx;
    logic [9:0] w_grant_num;
    logic [2:0] w_ptr_after;
    logic [5:0] w_grant_onehot;
    logic [5:0] w_motor_onehot;

    // Scan from the farthest candidate down so the nearest one to ptr wins
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand_idx[k];
            end
        end
    end

    assign w_grant_num    = ReqNum[10*w_grant_idx +: 10];
    assign w_ptr_after    = (w_grant_idx == 3'd5) ? 3'd0 : w_grant_idx + 3'd1;
    assign w_grant_onehot = 6'(1) << w_grant_idx;
    assign w_motor_onehot = 6'(1) << r_motor;

`ifdef SCHED_TIMEOUT_EN
    localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT - 1);
    logic [19:0] r_wdog;
    logic [19:0] w_wdog_next;
    logic [5:0]  r_err;
    logic [5:0]  w_err_next;
`endif

    // Next-state and output logic
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_gap_next   = r_gap_cnt;
        w_ack_next   = 6'd0;
        w_done_next  = 6'd0;
        w_motor_next = r_motor;
        w_pnum_next  = r_pnum;
`ifdef SCHED_TIMEOUT_EN
        w_wdog_next  = r_wdog;
        w_err_next   = 6'd0;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_motor_next = w_grant_idx;
                    w_pnum_next  = w_grant_num;
                    w_ack_next   = w_grant_onehot;
                    w_ptr_next   = w_ptr_after;
`ifdef SCHED_TIMEOUT_EN
                    w_wdog_next  = 20'd0;
`endif
                    if (w_grant_num != 10'd0) begin
                        w_state_next = S_LOAD;
                    end else begin
                        // Empty move: complete immediately, generator never enabled
                        w_done_next  = w_grant_onehot;
                        w_state_next = S_GAP;
                        w_gap_next   = GAP_LAST;
                    end
                end
            end
            S_LOAD: begin
                if (Busy) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!Busy) begin
                    w_done_next  = w_motor_onehot;
                    w_state_next = S_GAP;
                    w_gap_next   = GAP_LAST;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

`ifdef SCHED_TIMEOUT_EN
        // A normal completion in the same cycle takes precedence over the abort
        if ((r_state == S_LOAD || r_state == S_RUN) && w_state_next != S_GAP) begin
            if (r_wdog == WDOG_LAST) begin
                w_err_next   = w_motor_onehot;
                w_state_next = S_GAP;
                w_gap_next   = GAP_LAST;
            end else begin
                w_wdog_next = r_wdog + 20'd1;
            end
        end
`endif

        w_enable_next     = (w_state_next == S_LOAD) || (w_state_next == S_RUN);
        w_sched_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 3'd0;
            r_gap_cnt    <= '0;
            r_ack        <= 6'd0;
            r_done       <= 6'd0;
            r_motor      <= 3'd0;
            r_pnum       <= 10'd0;
            r_enable     <= 1'b0;
            r_sched_busy <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_gap_cnt    <= w_gap_next;
            r_ack        <= w_ack_next;
            r_done       <= w_done_next;
            r_motor      <= w_motor_next;
            r_pnum       <= w_pnum_next;
            r_enable     <= w_enable_next;
            r_sched_busy <= w_sched_busy_next;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= 20'd0;
            r_err  <= 6'd0;
        end else begin
            r_wdog <= w_wdog_next;
            r_err  <= w_err_next;
        end
    end

    assign Err = r_err;
`else
    assign Err = 6'd0;
`endif

    assign Ack       = r_ack;
    assign Done      = r_done;
    assign Motor     = r_motor;
    assign PulseNum  = r_pnum;
    assign Enable    = r_enable;
    assign SchedBusy = r_sched_busy;

endmodule

// File: tb/tb_pulse_sched.sv
// -----------------------------------------------------------------------------
// tb_pulse_sched
//
// Directed testbench for pulse_sched with GAP_CYCLES=4 and TIMEOUT=100. A small
// PulseSign stand-in raises Busy two cycles after Enable and drops it after
// 4*PulseNum further cycles. The stuck flag forces Busy high for the watchdog
// scenario, which runs only when SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pulse_sched;

    localparam int GAP = 4;

    logic        clk;
    logic        rst;
    logic [5:0]  Req;
    logic [59:0] ReqNum;
    logic [5:0]  Ack;
    logic [5:0]  Done;
    logic [5:0]  Err;
    logic [2:0]  Motor;
    logic [9:0]  PulseNum;
    logic        Enable;
    logic        Busy;
    logic        SchedBusy;

    int checks = 0;
    int errors = 0;

    pulse_sched #(
        .GAP_CYCLES (GAP),
        .TIMEOUT    (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Req       (Req),
        .ReqNum    (ReqNum),
        .Ack       (Ack),
        .Done      (Done),
        .Err       (Err),
        .Motor     (Motor),
        .PulseNum  (PulseNum),
        .Enable    (Enable),
        .Busy      (Busy),
        .SchedBusy (SchedBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PulseSign stand-in
    logic model_busy = 1'b0;
    int   model_cnt  = 0;
    bit   stuck      = 1'b0;

    always @(posedge clk) begin
        if (!Enable) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else begin
            model_cnt <= model_cnt + 1;
            if (model_cnt == 1)
                model_busy <= 1'b1;
            else if (model_cnt == 1 + 4 * int'(PulseNum))
                model_busy <= 1'b0;
        end
    end

    assign Busy = model_busy | stuck;

    // Running count of Done pulses, sampled on the falling edge
    int done_pulses = 0;
    always @(negedge clk) begin
        if (|Done) done_pulses <= done_pulses + 1;
    end

    // Wait on falling edges for Ack (sel 0), Done (1) or Err (2); bounded
    task automatic wait_evt(input int sel, input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < limit && !seen) begin
            @(negedge clk);
            cycles++;
            if ((sel == 0 && |Ack) || (sel == 1 && |Done) || (sel == 2 && |Err))
                seen = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b0;
        Req   = 6'd0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (Ack !== 6'd0)      begin errors++; $display("FAIL reset_ack: got %b expected 000000", Ack); end
        checks++; if (Done !== 6'd0)     begin errors++; $display("FAIL reset_done: got %b expected 000000", Done); end
        checks++; if (Err !== 6'd0)      begin errors++; $display("FAIL reset_err: got %b expected 000000", Err); end
        checks++; if (Motor !== 3'd0)    begin errors++; $display("FAIL reset_motor: got %0d expected 0", Motor); end
        checks++; if (PulseNum !== 10'd0) begin errors++; $display("FAIL reset_pulsenum: got %0d expected 0", PulseNum); end
        checks++; if (Enable !== 1'b0)   begin errors++; $display("FAIL reset_enable: got %b expected 0", Enable); end
        checks++; if (SchedBusy !== 1'b0) begin errors++; $display("FAIL reset_schedbusy: got %b expected 0", SchedBusy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (SchedBusy !== 1'b0) begin errors++; $display("FAIL idle_schedbusy: got %b expected 0", SchedBusy); end
        $display("txn: reset released");
    endtask

    task automatic test_single();
        int cyc;
        bit seen;
        ReqNum = 60'd0;
        ReqNum[20 +: 10] = 10'd3;
        Req = 6'b000100;
        @(negedge clk);
        checks++; if (Ack !== 6'b000100) begin errors++; $display("FAIL single_ack: got %b expected 000100", Ack); end
        checks++; if (Motor !== 3'd2)    begin errors++; $display("FAIL single_motor: got %0d expected 2", Motor); end
        checks++; if (PulseNum !== 10'd3) begin errors++; $display("FAIL single_pulsenum: got %0d expected 3", PulseNum); end
        checks++; if (Enable !== 1'b1)   begin errors++; $display("FAIL single_enable: got %b expected 1", Enable); end
        checks++; if (SchedBusy !== 1'b1) begin errors++; $display("FAIL single_schedbusy: got %b expected 1", SchedBusy); end
        Req = 6'd0;
        $display("txn: grant motor %0d count %0d", Motor, PulseNum);
        wait_evt(1, 100, cyc, seen);
        checks++; if (!seen || cyc != 15) begin errors++; $display("FAIL single_done_latency: got %0d cycles (seen=%0d) expected 15", cyc, seen); end
        checks++; if (Done !== 6'b000100) begin errors++; $display("FAIL single_done: got %b expected 000100", Done); end
        checks++; if (Enable !== 1'b0)   begin errors++; $display("FAIL single_enable_fall: got %b expected 0", Enable); end
        checks++; if (Err !== 6'd0)      begin errors++; $display("FAIL single_err: got %b expected 000000", Err); end
        $display("txn: done motor 2 after %0d cycles", cyc);
        for (int j = 1; j <= GAP; j++) begin
            @(negedge clk);
            checks++; if (Done !== 6'd0) begin errors++; $display("FAIL gap_done_%0d: got %b expected 000000", j, Done); end
            checks++; if (Enable !== 1'b0) begin errors++; $display("FAIL gap_enable_%0d: got %b expected 0", j, Enable); end
            checks++; if (SchedBusy !== (j < GAP)) begin errors++; $display("FAIL gap_schedbusy_%0d: got %b expected %0d", j, SchedBusy, (j < GAP)); end
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit seen;
        int exp_m;
        apply_reset();
        for (int i = 0; i < 6; i++) ReqNum[10*i +: 10] = 10'd1;
        Req = 6'b111111;
        for (int m = 0; m < 7; m++) begin
            exp_m = m % 6;
            wait_evt(0, 20, cyc, seen);
            checks++; if (!seen || cyc != ((m == 0) ? 1 : GAP + 1)) begin errors++; $display("FAIL rr_ack_spacing_%0d: got %0d cycles (seen=%0d) expected %0d", m, cyc, seen, (m == 0) ? 1 : GAP + 1); end
            checks++; if (Ack !== 6'(1 << exp_m)) begin errors++; $display("FAIL rr_ack_%0d: got %b expected motor %0d", m, Ack, exp_m); end
            checks++; if (Motor !== 3'(exp_m)) begin errors++; $display("FAIL rr_motor_%0d: got %0d expected %0d", m, Motor, exp_m); end
            $display("txn: rr grant motor %0d", Motor);
            if (m == 6) Req = 6'd0;
            wait_evt(1, 20, cyc, seen);
            checks++; if (!seen || cyc != 7) begin errors++; $display("FAIL rr_done_latency_%0d: got %0d cycles (seen=%0d) expected 7", m, cyc, seen); end
            checks++; if (Done !== 6'(1 << exp_m)) begin errors++; $display("FAIL rr_done_%0d: got %b expected motor %0d", m, Done, exp_m); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_zero_count();
        bit en_seen = 1'b0;
        ReqNum[40 +: 10] = 10'd0;
        Req = 6'b010000;
        @(negedge clk);
        checks++; if (Ack !== 6'b010000)  begin errors++; $display("FAIL zero_ack: got %b expected 010000", Ack); end
        checks++; if (Done !== 6'b010000) begin errors++; $display("FAIL zero_done: got %b expected 010000", Done); end
        checks++; if (Motor !== 3'd4)     begin errors++; $display("FAIL zero_motor: got %0d expected 4", Motor); end
        checks++; if (PulseNum !== 10'd0) begin errors++; $display("FAIL zero_pulsenum: got %0d expected 0", PulseNum); end
        $display("txn: zero-count grant motor %0d", Motor);
        if (Enable) en_seen = 1'b1;
        for (int j = 1; j <= GAP + 1; j++) begin
            @(negedge clk);
            if (Enable) en_seen = 1'b1;
            if (j < GAP + 1) begin
                checks++; if (Ack !== 6'd0) begin errors++; $display("FAIL zero_gap_ack_%0d: got %b expected 000000", j, Ack); end
            end else begin
                checks++; if (Ack !== 6'b010000) begin errors++; $display("FAIL zero_regrant: got %b expected 010000", Ack); end
                Req = 6'd0;
            end
        end
        checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL zero_enable: got %b expected 0", en_seen); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit seen;
        apply_reset();
        ReqNum[10 +: 10] = 10'd2;
        ReqNum[20 +: 10] = 10'd5;
        ReqNum[30 +: 10] = 10'd2;
        Req = 6'b000100;
        wait_evt(0, 5, cyc, seen);
        checks++; if (Ack !== 6'b000100) begin errors++; $display("FAIL mid_first_ack: got %b expected 000100", Ack); end
        Req = 6'b001010;
        repeat (5) @(negedge clk);
        checks++; if (Enable !== 1'b1) begin errors++; $display("FAIL mid_running: got %b expected 1", Enable); end
        rst = 1'b0;
        #1;
        checks++; if (Enable !== 1'b0)    begin errors++; $display("FAIL mid_enable: got %b expected 0", Enable); end
        checks++; if (SchedBusy !== 1'b0) begin errors++; $display("FAIL mid_schedbusy: got %b expected 0", SchedBusy); end
        checks++; if (Motor !== 3'd0)     begin errors++; $display("FAIL mid_motor: got %0d expected 0", Motor); end
        checks++; if (PulseNum !== 10'd0) begin errors++; $display("FAIL mid_pulsenum: got %0d expected 0", PulseNum); end
        checks++; if (Done !== 6'd0)      begin errors++; $display("FAIL mid_done: got %b expected 000000", Done); end
        $display("txn: reset during run");
        @(negedge clk);
        rst = 1'b1;
        wait_evt(0, 5, cyc, seen);
        checks++; if (!seen || cyc != 1) begin errors++; $display("FAIL mid_regrant_latency: got %0d cycles (seen=%0d) expected 1", cyc, seen); end
        checks++; if (Ack !== 6'b000010) begin errors++; $display("FAIL mid_regrant: got %b expected 000010", Ack); end
        $display("txn: grant motor %0d after reset", Motor);
        Req = 6'd0;
        wait_evt(1, 50, cyc, seen);
        checks++; if (Done !== 6'b000010) begin errors++; $display("FAIL mid_done_after: got %b expected 000010", Done); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_drop_req();
        int cyc;
        bit seen;
        bit extra_ack = 1'b0;
        Req = 6'b001000;
        wait_evt(0, 5, cyc, seen);
        checks++; if (Ack !== 6'b001000) begin errors++; $display("FAIL drop_ack: got %b expected 001000", Ack); end
        @(negedge clk);
        Req = 6'd0;
        wait_evt(1, 50, cyc, seen);
        checks++; if (!seen || cyc != 10) begin errors++; $display("FAIL drop_done_latency: got %0d cycles (seen=%0d) expected 10", cyc, seen); end
        checks++; if (Done !== 6'b001000) begin errors++; $display("FAIL drop_done: got %b expected 001000", Done); end
        $display("txn: motor 3 completed after Req dropped");
        repeat (10) begin
            @(negedge clk);
            if (|Ack) extra_ack = 1'b1;
        end
        checks++; if (extra_ack !== 1'b0) begin errors++; $display("FAIL drop_no_regrant: got %b expected 0", extra_ack); end
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit seen;
        int done_before;
        stuck = 1'b1;
        ReqNum[50 +: 10] = 10'd1;
        ReqNum[0 +: 10]  = 10'd1;
        Req = 6'b100000;
        wait_evt(0, 5, cyc, seen);
        checks++; if (Ack !== 6'b100000) begin errors++; $display("FAIL to_ack: got %b expected 100000", Ack); end
        Req = 6'd0;
        done_before = done_pulses;
        wait_evt(2, 300, cyc, seen);
        checks++; if (!seen || cyc != 100) begin errors++; $display("FAIL to_latency: got %0d cycles (seen=%0d) expected 100", cyc, seen); end
        checks++; if (Err !== 6'b100000) begin errors++; $display("FAIL to_err: got %b expected 100000", Err); end
        checks++; if (Enable !== 1'b0)   begin errors++; $display("FAIL to_enable: got %b expected 0", Enable); end
        checks++; if (done_pulses != done_before || Done !== 6'd0) begin errors++; $display("FAIL to_no_done: got %0d pulses expected 0", done_pulses - done_before); end
        $display("txn: watchdog abort motor 5");
        Req = 6'b000001;
        wait_evt(0, 20, cyc, seen);
        checks++; if (!seen || cyc != GAP + 1) begin errors++; $display("FAIL to_next_spacing: got %0d cycles (seen=%0d) expected %0d", cyc, seen, GAP + 1); end
        checks++; if (Ack !== 6'b000001) begin errors++; $display("FAIL to_next_ack: got %b expected 000001", Ack); end
        stuck = 1'b0;
        Req = 6'd0;
        wait_evt(1, 50, cyc, seen);
        checks++; if (Done !== 6'b000001) begin errors++; $display("FAIL to_next_done: got %b expected 000001", Done); end
        repeat (8) @(negedge clk);
    endtask
`endif

    initial begin
        rst    = 1'b0;
        Req    = 6'd0;
        ReqNum = 60'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_reset_mid_run();
        test_drop_req();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
